// File: rtl/line_mem_arbiter.sv
// rtl/line_mem_arbiter.sv - I/D cache line requests arbitrated onto one burst memory port
// Each line transfer becomes BEATS sequential beats; one line-level response per request.
module line_mem_arbiter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_line_read,
  input  logic [31:0]        i_line_address,
  output logic [LINE_W-1:0]  i_line_rdata,
  output logic               i_line_resp,
  input  logic               d_line_read,
  input  logic               d_line_write,
  input  logic [31:0]        d_line_address,
  input  logic [LINE_W-1:0]  d_line_wdata,
  output logic [LINE_W-1:0]  d_line_rdata,
  output logic               d_line_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [31:0]        pmem_address,
  output logic [BURST_W-1:0] pmem_wdata,
  input  logic [BURST_W-1:0] pmem_rdata,
  input  logic               pmem_resp
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OW    = $clog2(BURST_W);
  localparam logic [31:0] ALIGN_MASK = ~32'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      beat;
  logic [CW+OW-1:0]   beat_off;
  logic               owner_d, last_owner_d;
  logic [31:0]        addr_q;
  logic [LINE_W-1:0]  wdata_q, fill_q, line_in;
  logic [LINE_W-1:0]  i_buf, d_buf;
  logic               i_req, d_req, grant_d, last_beat;

  assign i_req     = i_line_read;
  assign d_req     = d_line_read | d_line_write;
  // On a tie the grant goes to whoever was not served last.
  assign grant_d   = d_req & (~i_req | ~last_owner_d);
  assign last_beat = (beat == CW'(BEATS - 1));
  assign beat_off  = {beat, {OW{1'b0}}};

  // Reads assemble into a staging line so the owner's rdata stays stable until the line is whole.
  always_comb begin
    line_in = fill_q;
    line_in[beat_off +: BURST_W] = pmem_rdata;
  end

  always_comb begin
    state_nxt    = state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_line_resp  = 1'b0;
    d_line_resp  = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req)
          state_nxt = (grant_d && d_line_write) ? WR_BURST : RD_BURST;
      end
      RD_BURST: begin
        pmem_read    = 1'b1;
        pmem_address = addr_q & ALIGN_MASK;
        if (pmem_resp && last_beat) state_nxt = DONE;
      end
      WR_BURST: begin
        pmem_write   = 1'b1;
        pmem_address = addr_q & ALIGN_MASK;
        pmem_wdata   = wdata_q[beat_off +: BURST_W];
        if (pmem_resp && last_beat) state_nxt = DONE;
      end
      DONE: begin
        i_line_resp = ~owner_d;
        d_line_resp = owner_d;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      beat         <= '0;
      owner_d      <= 1'b0;
      last_owner_d <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      fill_q       <= '0;
      i_buf        <= '0;
      d_buf        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner_d <= grant_d;
            addr_q  <= grant_d ? d_line_address : i_line_address;
            if (grant_d && d_line_write) wdata_q <= d_line_wdata;
          end
        end
        RD_BURST, WR_BURST: begin
          if (pmem_resp) begin
            beat <= last_beat ? '0 : beat + 1'b1;
            if (state == RD_BURST) begin
              fill_q <= line_in;
              if (last_beat) begin
                if (owner_d) d_buf <= line_in;
                else         i_buf <= line_in;
              end
            end
          end
        end
        DONE:    last_owner_d <= owner_d;
        default: ;
      endcase
    end
  end

  assign i_line_rdata = i_buf;
  assign d_line_rdata = d_buf;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb/tb_line_mem_arbiter.sv - directed and randomized checks of line_mem_arbiter against a line-level model
// A beat-level memory responder sits on the pmem port; the main sequence checks line results and ordering.
module tb_line_mem_arbiter;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               i_line_read = 1'b0;
  logic [31:0]        i_line_address = '0;
  logic [LINE_W-1:0]  i_line_rdata;
  logic               i_line_resp;
  logic               d_line_read = 1'b0;
  logic               d_line_write = 1'b0;
  logic [31:0]        d_line_address = '0;
  logic [LINE_W-1:0]  d_line_wdata = '0;
  logic [LINE_W-1:0]  d_line_rdata;
  logic               d_line_resp;
  logic               pmem_read, pmem_write;
  logic [31:0]        pmem_address;
  logic [BURST_W-1:0] pmem_wdata;
  logic [BURST_W-1:0] pmem_rdata = '0;
  logic               pmem_resp = 1'b0;

  line_mem_arbiter #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst(rst),
    .i_line_read(i_line_read), .i_line_address(i_line_address),
    .i_line_rdata(i_line_rdata), .i_line_resp(i_line_resp),
    .d_line_read(d_line_read), .d_line_write(d_line_write),
    .d_line_address(d_line_address), .d_line_wdata(d_line_wdata),
    .d_line_rdata(d_line_rdata), .d_line_resp(d_line_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory contents: physical store (written only by DUT beats) and reference store (intended lines).
  logic [LINE_W-1:0] pmem_store [logic [26:0]];
  logic [LINE_W-1:0] ref_mem    [logic [26:0]];

  function automatic logic [LINE_W-1:0] init_line(input logic [26:0] idx);
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++)
      v[k*32 +: 32] = (32'(idx) * 32'h9E3779B1) ^ (32'(k) << 24);
    return v;
  endfunction

  function automatic logic [LINE_W-1:0] pmem_get(input logic [31:0] a);
    return pmem_store.exists(a[31:5]) ? pmem_store[a[31:5]] : init_line(a[31:5]);
  endfunction

  function automatic logic [LINE_W-1:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a[31:5]) ? ref_mem[a[31:5]] : init_line(a[31:5]);
  endfunction

  // Memory responder: one beat per accepted pmem_resp, optional wait states.
  int                resp_period = 1;
  logic [LINE_W-1:0] exp_wline = '0;
  bit                in_burst = 1'b0;
  int                rbeat = 0;
  int                scnt = 0;
  logic [31:0]       burst_addr = '0;
  logic [LINE_W-1:0] rline = '0;
  logic [LINE_W-1:0] wacc = '0;
  logic [31:0]       log_addr[$];
  bit                log_wr[$];

  always @(negedge clk) begin
    if (pmem_read || pmem_write) begin
      if (!in_burst) begin
        in_burst   = 1'b1;
        rbeat      = 0;
        scnt       = 0;
        burst_addr = pmem_address;
        rline      = pmem_get(pmem_address);
        log_addr.push_back(pmem_address);
        log_wr.push_back(pmem_write);
      end
      chk("pmem_address_stable", LINE_W'(pmem_address), LINE_W'(burst_addr));
      chk("pmem_strobe_exclusive", LINE_W'(pmem_read & pmem_write), LINE_W'(0));
      if (rbeat >= BEATS) begin
        chk("burst_overrun", LINE_W'(rbeat), LINE_W'(BEATS - 1));
        pmem_resp = 1'b0;
      end else begin
        if (pmem_write)
          chk("pmem_wdata_beat", LINE_W'(pmem_wdata), LINE_W'(exp_wline[rbeat*BURST_W +: BURST_W]));
        if (scnt % resp_period == resp_period - 1) begin
          pmem_resp  = 1'b1;
          pmem_rdata = rline[rbeat*BURST_W +: BURST_W];
          if (pmem_write) wacc[rbeat*BURST_W +: BURST_W] = pmem_wdata;
          rbeat++;
          if (rbeat == BEATS && pmem_write) pmem_store[burst_addr[31:5]] = wacc;
        end else begin
          pmem_resp  = 1'b0;
          pmem_rdata = {$urandom, $urandom};
        end
      end
      scnt++;
    end else begin
      in_burst  = 1'b0;
      pmem_resp = 1'b0;
    end
  end

  // Line-level model state.
  bit                model_last_d = 1'b0;
  logic [LINE_W-1:0] last_i = '0;
  logic [LINE_W-1:0] last_d = '0;

  task automatic do_reset();
    i_line_read  = 1'b0;
    d_line_read  = 1'b0;
    d_line_write = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_last_d = 1'b0;
    last_i = '0;
    last_d = '0;
  endtask

  task automatic wait_any(output bit gi, output bit gd, output int cyc);
    gi = 1'b0; gd = 1'b0; cyc = 0;
    while (!gi && !gd && cyc < 200) begin
      @(negedge clk);
      cyc++;
      gi = i_line_resp;
      gd = d_line_resp;
    end
    chk("resp_timeout", LINE_W'(gi | gd), LINE_W'(1));
  endtask

  // One transaction set: I read and/or D read/write issued in the same cycle.
  task automatic run_txn(input bit use_i, input bit use_d, input bit d_wr,
                         input logic [31:0] ia, input logic [31:0] da, input logic [LINE_W-1:0] dw);
    bit i_pend = use_i;
    bit d_pend = use_d;
    bit first = 1'b1;
    bit gi, gd, exp_d_first;
    int lat;
    exp_d_first    = use_d && (!use_i || !model_last_d);
    i_line_read    = use_i;
    i_line_address = ia;
    d_line_read    = use_d & ~d_wr;
    d_line_write   = use_d & d_wr;
    d_line_address = da;
    d_line_wdata   = dw;
    if (use_d && d_wr) exp_wline = dw;
    while (i_pend || d_pend) begin
      wait_any(gi, gd, lat);
      if (!gi && !gd) begin
        i_pend = 1'b0;
        d_pend = 1'b0;
      end else begin
        chk("resp_exclusive", LINE_W'(gi & gd), LINE_W'(0));
        if (first) begin
          chk("grant_order", LINE_W'(gd), LINE_W'(exp_d_first));
          chk("first_latency", LINE_W'(lat), LINE_W'(1 + BEATS * resp_period));
          first = 1'b0;
        end
        if (gd) begin
          chk("d_resp_requested", LINE_W'(d_pend), LINE_W'(1));
          if (d_wr) begin
            ref_mem[da[31:5]] = dw;
            chk("pmem_line_written", pmem_get(da), dw);
            chk("d_rdata_kept_on_write", d_line_rdata, last_d);
          end else begin
            last_d = ref_get(da);
            chk("d_line_rdata", d_line_rdata, last_d);
          end
          d_pend = 1'b0; d_line_read = 1'b0; d_line_write = 1'b0;
          model_last_d = 1'b1;
        end
        if (gi) begin
          chk("i_resp_requested", LINE_W'(i_pend), LINE_W'(1));
          last_i = ref_get(ia);
          chk("i_line_rdata", i_line_rdata, last_i);
          i_pend = 1'b0; i_line_read = 1'b0;
          model_last_d = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("resp_single_cycle", LINE_W'({i_line_resp, d_line_resp}), LINE_W'(0));
    chk("idle_after_done", LINE_W'({pmem_read, pmem_write}), LINE_W'(0));
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h1000_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [LINE_W-1:0] line_a, line_b, dw;
    logic [31:0] ia, da;
    bit gi, gd;
    int lat, k, mode;

    // Reset state
    @(negedge clk);
    chk("rst_pmem_strobes", LINE_W'({pmem_read, pmem_write}), LINE_W'(0));
    chk("rst_pmem_address", LINE_W'(pmem_address), LINE_W'(0));
    chk("rst_pmem_wdata", LINE_W'(pmem_wdata), LINE_W'(0));
    chk("rst_resps", LINE_W'({i_line_resp, d_line_resp}), LINE_W'(0));
    chk("rst_i_rdata", i_line_rdata, LINE_W'(0));
    chk("rst_d_rdata", d_line_rdata, LINE_W'(0));
    rst = 1'b1;
    @(negedge clk);

    // Directed I read with known beats
    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    pmem_store[27'h3] = line_a;
    ref_mem[27'h3]    = line_a;
    log_addr.delete(); log_wr.delete();
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0064, '0, '0);
    chk("i_read_rdata_literal", i_line_rdata, line_a);
    chk("i_read_burst_count", LINE_W'(log_addr.size()), LINE_W'(1));
    if (log_addr.size() == 1) begin
      chk("i_read_pmem_address", LINE_W'(log_addr[0]), LINE_W'(32'h0000_0060));
      chk("i_read_is_read", LINE_W'(log_wr[0]), LINE_W'(0));
    end

    // Directed D write, beats A,B,C,D
    line_b = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    log_addr.delete(); log_wr.delete();
    run_txn(1'b0, 1'b1, 1'b1, '0, 32'h8000_001C, line_b);
    chk("d_write_stored", pmem_store.exists(27'h400_0000) ? pmem_store[27'h400_0000] : '0, line_b);
    if (log_addr.size() == 1) begin
      chk("d_write_pmem_address", LINE_W'(log_addr[0]), LINE_W'(32'h8000_0000));
      chk("d_write_is_write", LINE_W'(log_wr[0]), LINE_W'(1));
    end

    // Conflict after reset: D first; D re-requests at once, so I wins the next tie
    do_reset();
    @(negedge clk);
    i_line_read = 1'b1; i_line_address = 32'h0000_0064;
    d_line_read = 1'b1; d_line_address = 32'h0000_0120;
    wait_any(gi, gd, lat);
    chk("conflict1_d_first", LINE_W'({gi, gd}), LINE_W'(2'b01));
    chk("conflict1_d_rdata", d_line_rdata, ref_get(32'h0000_0120));
    d_line_address = 32'h0000_0140;
    wait_any(gi, gd, lat);
    chk("conflict2_i_first", LINE_W'({gi, gd}), LINE_W'(2'b10));
    chk("conflict2_i_rdata", i_line_rdata, line_a);
    i_line_read = 1'b0;
    wait_any(gi, gd, lat);
    chk("conflict3_d_again", LINE_W'({gi, gd}), LINE_W'(2'b01));
    chk("conflict3_d_rdata", d_line_rdata, ref_get(32'h0000_0140));
    d_line_read = 1'b0;
    last_i = line_a; last_d = ref_get(32'h0000_0140); model_last_d = 1'b1;
    @(negedge clk);

    // Wait-stated memory: pmem_resp every 3rd cycle
    resp_period = 3;
    run_txn(1'b0, 1'b1, 1'b1, '0, 32'h0000_0200, rand_line());
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0210, '0, '0);

    // Reset mid-burst after two read beats
    resp_period = 1;
    i_line_read = 1'b1; i_line_address = 32'h0000_0060;
    k = 0;
    while (rbeat < 2 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    chk("midburst_reached", LINE_W'(rbeat >= 2), LINE_W'(1));
    rst = 1'b0;
    #1;
    chk("midburst_rst_strobes", LINE_W'({pmem_read, pmem_write}), LINE_W'(0));
    chk("midburst_rst_resps", LINE_W'({i_line_resp, d_line_resp}), LINE_W'(0));
    chk("midburst_rst_i_rdata", i_line_rdata, LINE_W'(0));
    i_line_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_last_d = 1'b0; last_i = '0; last_d = '0;
    @(negedge clk);
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0060, '0, '0);
    chk("post_rst_i_rdata", i_line_rdata, line_a);

    // Back-to-back I reads
    i_line_read = 1'b1; i_line_address = 32'h0000_0300;
    wait_any(gi, gd, lat);
    line_a = ref_get(32'h0000_0300);
    chk("b2b_first_rdata", i_line_rdata, line_a);
    i_line_address = 32'h0000_0320;
    @(negedge clk);
    chk("b2b_idle_gap", LINE_W'({pmem_read, pmem_write}), LINE_W'(0));
    k = 0; gi = 1'b0;
    while (!gi && k < 50) begin
      @(negedge clk);
      k++;
      gi = i_line_resp;
      if (!gi) chk("b2b_rdata_held", i_line_rdata, line_a);
    end
    chk("b2b_second_resp", LINE_W'(gi), LINE_W'(1));
    chk("b2b_second_rdata", i_line_rdata, ref_get(32'h0000_0320));
    i_line_read = 1'b0;
    last_i = ref_get(32'h0000_0320); model_last_d = 1'b0;
    @(negedge clk);

    // Randomized mix over a small set of lines
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      resp_period = $urandom_range(1, 3);
      ia = rand_addr();
      da = rand_addr();
      dw = rand_line();
      run_txn(mode != 1, mode != 0, 1'($urandom_range(0, 1)), ia, da, dw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
